// File: rtl/operand_fetch_pkg.sv
// Shared definitions for the operand fetch path: bus unit-select codes,
// fetch FSM states and the readable-unit decode used by the fetch master.
package operand_fetch_pkg;

   // Unit-select codes carried in the top nibble of a bus address.
   // The data mux decodes the same constants.
   localparam logic [3:0] MAIN_MEM   = 4'd0;
   localparam logic [3:0] REGISTER   = 4'd1;
   localparam logic [3:0] INSTR_MEM  = 4'd2;
   localparam logic [3:0] MATRIX_ALU = 4'd3;
   localparam logic [3:0] INT_ALU    = 4'd4;
   localparam logic [3:0] EXECUTE    = 4'd5;

   // Width of the read-latency counter; bounds the legal read latency to 7.
   localparam int CNT_W = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD_A = 2'd1,
      RD_B = 2'd2,
      DONE = 2'd3
   } fetch_state_t;

   // Only units that sit behind the data mux can be read. The register
   // file has a unit code but is not on the mux, so it is unreadable.
   function automatic logic is_readable_unit(input logic [3:0] unit_sel);
      case (unit_sel)
         MAIN_MEM, INSTR_MEM, MATRIX_ALU, INT_ALU, EXECUTE: return 1'b1;
         default:                                           return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/operand_fetch_read_latency_counter.sv
// Counts the cycles of one bus read and flags the cycle in which the data
// mux output is valid (count == READ_LAT).
module read_latency_counter
   import operand_fetch_pkg::*;
#(
   parameter int READ_LAT = 2
)
(
   input  logic Clk,
   input  logic nReset,
   input  logic clear,
   input  logic inc,
   output logic done
);

   logic [CNT_W-1:0] count_reg;

   // Count register: clear wins over increment so the next read starts at 0.
   always_ff @(posedge Clk) begin
      if (!nReset) begin
         count_reg <= '0;
      end else if (clear) begin
         count_reg <= '0;
      end else if (inc) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   assign done = (count_reg == CNT_W'(READ_LAT));

endmodule

// File: rtl/operand_fetch.sv
// Bus read master downstream of the data mux. Takes a one- or two-operand
// fetch request, performs back-to-back reads with a fixed latency and
// presents the captured operands to the ALU issue stage via valid/ready.
module operand_fetch
   import operand_fetch_pkg::*;
#(
   parameter int READ_LAT = 2,
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 256
)
(
   input  logic              Clk,
   input  logic              nReset,
   input  logic              ReqValid,
   output logic              ReqReady,
   input  logic [ADDR_W-1:0] ReqSrcA,
   input  logic [ADDR_W-1:0] ReqSrcB,
   input  logic              ReqTwoOps,
   output logic              nRead,
   output logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] DataMuxOut,
   output logic              OpValid,
   input  logic              OpReady,
   output logic [DATA_W-1:0] OperandA,
   output logic [DATA_W-1:0] OperandB,
   output logic              AddrErr
);

   // The 3-bit counter can only reach latencies up to 7.
   if (READ_LAT < 1 || READ_LAT > 7) begin : g_lat_check
      $error("operand_fetch: READ_LAT out of range 1..7");
   end

   fetch_state_t      state_reg, state_next;
   logic [ADDR_W-1:0] src_a_reg, src_b_reg;
   logic              two_ops_reg;
   logic [DATA_W-1:0] op_a_reg, op_b_reg;
   logic              addr_err_reg;
   logic              req_bad;
   logic              cnt_inc, cnt_clr, cnt_done;

   // A request is rejected up front if any address it actually uses is unreadable.
   assign req_bad = !is_readable_unit(ReqSrcA[ADDR_W-1 -: 4]) ||
                    (ReqTwoOps && !is_readable_unit(ReqSrcB[ADDR_W-1 -: 4]));

   read_latency_counter #(
      .READ_LAT (READ_LAT)
   ) u_lat_cnt (
      .Clk    (Clk),
      .nReset (nReset),
      .clear  (cnt_clr),
      .inc    (cnt_inc),
      .done   (cnt_done)
   );

   // State register plus request latching and operand capture.
   always_ff @(posedge Clk) begin
      if (!nReset) begin
         state_reg    <= IDLE;
         src_a_reg    <= '0;
         src_b_reg    <= '0;
         two_ops_reg  <= 1'b0;
         op_a_reg     <= '0;
         op_b_reg     <= '0;
         addr_err_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            IDLE: begin
               if (ReqValid) begin
                  src_a_reg    <= ReqSrcA;
                  src_b_reg    <= ReqSrcB;
                  two_ops_reg  <= ReqTwoOps;
                  op_a_reg     <= '0;
                  op_b_reg     <= '0;
                  addr_err_reg <= req_bad;
               end
            end
            RD_A: if (cnt_done) op_a_reg <= DataMuxOut;
            RD_B: if (cnt_done) op_b_reg <= DataMuxOut;
            DONE: if (OpReady) addr_err_reg <= 1'b0;
            default: ;
         endcase
      end
   end

   // Next-state logic and bus/handshake output decode.
   always_comb begin
      state_next = state_reg;
      ReqReady   = 1'b0;
      nRead      = 1'b1;
      address    = '0;
      OpValid    = 1'b0;
      cnt_inc    = 1'b0;
      cnt_clr    = 1'b0;
      case (state_reg)
         IDLE: begin
            // Not ready while reset is asserted, even though state is already IDLE.
            ReqReady = nReset;
            if (ReqValid) state_next = req_bad ? DONE : RD_A;
         end
         RD_A: begin
            nRead   = 1'b0;
            address = src_a_reg;
            if (cnt_done) begin
               cnt_clr    = 1'b1;
               state_next = two_ops_reg ? RD_B : DONE;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         RD_B: begin
            nRead   = 1'b0;
            address = src_b_reg;
            if (cnt_done) begin
               cnt_clr    = 1'b1;
               state_next = DONE;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         DONE: begin
            OpValid = 1'b1;
            if (OpReady) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign OperandA = op_a_reg;
   assign OperandB = op_b_reg;
   assign AddrErr  = addr_err_reg;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: a latency-accurate data mux model,
// a table of directed fetches, randomized fetches against a reference model,
// and hand-written reset sequences.
module tb_operand_fetch;

   localparam int READ_LAT = 2;
   localparam logic [255:0] JUNK = {8{32'hDEADBEEF}};

   logic         Clk;
   logic         nReset;
   logic         ReqValid;
   logic         ReqReady;
   logic [15:0]  ReqSrcA;
   logic [15:0]  ReqSrcB;
   logic         ReqTwoOps;
   logic         nRead;
   logic [15:0]  address;
   logic [255:0] DataMuxOut;
   logic         OpValid;
   logic         OpReady;
   logic [255:0] OperandA;
   logic [255:0] OperandB;
   logic         AddrErr;

   int checks = 0;
   int errors = 0;

   operand_fetch #(
      .READ_LAT (READ_LAT),
      .ADDR_W   (16),
      .DATA_W   (256)
   ) dut (
      .Clk        (Clk),
      .nReset     (nReset),
      .ReqValid   (ReqValid),
      .ReqReady   (ReqReady),
      .ReqSrcA    (ReqSrcA),
      .ReqSrcB    (ReqSrcB),
      .ReqTwoOps  (ReqTwoOps),
      .nRead      (nRead),
      .address    (address),
      .DataMuxOut (DataMuxOut),
      .OpValid    (OpValid),
      .OpReady    (OpReady),
      .OperandA   (OperandA),
      .OperandB   (OperandB),
      .AddrErr    (AddrErr)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Per-address contents of the bus.
   function automatic logic [255:0] data_for(input logic [15:0] a);
      logic [255:0] d;
      for (int i = 0; i < 16; i++) d[i*16 +: 16] = a ^ 16'(i * 16'h1111) ^ 16'hA5A5;
      return d;
   endfunction

   // Data mux model: source unit registers the read, mux registers again.
   logic [255:0] stage1;
   always @(posedge Clk) begin
      stage1     <= nRead ? JUNK : data_for(address);
      DataMuxOut <= stage1;
   end

   function automatic logic unit_ok(input logic [15:0] a);
      return a[15:12] inside {4'd0, 4'd2, 4'd3, 4'd4, 4'd5};
   endfunction

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One fetch: issue, follow the bus, check latency/operands, optional backpressure.
   task automatic run_txn(input logic [15:0] a, input logic [15:0] b, input logic two,
                          input int hold, input logic junk,
                          input int exp_lat, input logic exp_err, input int exp_low);
      logic [255:0] ea, eb;
      int lat, low, w;
      ea = exp_err ? 256'd0 : data_for(a);
      eb = (exp_err || !two) ? 256'd0 : data_for(b);
      @(negedge Clk);
      w = 0;
      while (!ReqReady && w < 20) begin
         @(negedge Clk);
         w++;
      end
      chk("req_ready_idle", ReqReady, 1);
      ReqValid  = 1'b1;
      ReqSrcA   = a;
      ReqSrcB   = b;
      ReqTwoOps = two;
      @(negedge Clk);
      ReqValid  = 1'b0;
      ReqSrcA   = 16'($urandom);
      ReqSrcB   = 16'($urandom);
      ReqTwoOps = 1'($urandom);
      lat = 1;
      low = 0;
      while (!OpValid && lat < 40) begin
         if (!nRead) begin
            chk("address", address, (low < READ_LAT + 1) ? a : b);
            low++;
         end
         @(negedge Clk);
         lat++;
      end
      chk("latency", lat, exp_lat);
      chk("strobe_cycles", low, exp_low);
      chk("nread_done", nRead, 1);
      chk("operand_a", OperandA, ea);
      chk("operand_b", OperandB, eb);
      chk("addr_err", AddrErr, exp_err);
      for (int h = 0; h < hold; h++) begin
         ReqValid = junk;
         ReqSrcA  = 16'($urandom_range(0, 16'h5FFF));
         @(negedge Clk);
         chk("hold_valid", OpValid, 1);
         chk("hold_operand_a", OperandA, ea);
         chk("hold_operand_b", OperandB, eb);
         chk("hold_nread", nRead, 1);
      end
      OpReady = 1'b1;
      @(negedge Clk);
      OpReady  = 1'b0;
      ReqValid = 1'b0;
      chk("valid_dropped", OpValid, 0);
      chk("err_dropped", AddrErr, 0);
      chk("idle_after_ack", ReqReady, 1);
      @(negedge Clk);
      chk("no_accept_on_ack", nRead, 1);
      $display("txn a=%h b=%h two=%b hold=%0d lat=%0d strobes=%0d err=%b", a, b, two, hold, lat, low, AddrErr);
   endtask

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        two;
      int          hold;
      logic        junk;
      int          lat;
      logic        err;
      int          low;
   } vec_t;

   vec_t vecs[10];

   initial begin
      logic [15:0] ra, rb;
      logic        rtwo, rerr;
      int          rlat, rlow;

      nReset    = 1'b0;
      ReqValid  = 1'b1;
      ReqSrcA   = 16'h0040;
      ReqSrcB   = 16'h0000;
      ReqTwoOps = 1'b0;
      OpReady   = 1'b0;

      // Reset held two cycles with a request pending.
      repeat (2) begin
         @(negedge Clk);
         chk("rst_nread", nRead, 1);
         chk("rst_opvalid", OpValid, 0);
         chk("rst_operand_a", OperandA, 0);
         chk("rst_reqready", ReqReady, 0);
         chk("rst_address", address, 0);
      end
      nReset   = 1'b1;
      ReqValid = 1'b0;
      #1;
      chk("rst_release_ready", ReqReady, 1);

      vecs[0] = '{16'h0040, 16'h0000, 1'b0, 0, 1'b0, 4, 1'b0, 3};
      vecs[1] = '{16'h2010, 16'h4008, 1'b1, 0, 1'b0, 7, 1'b0, 6};
      vecs[2] = '{16'h2010, 16'h4008, 1'b1, 5, 1'b1, 7, 1'b0, 6};
      vecs[3] = '{16'h1000, 16'h0000, 1'b0, 0, 1'b0, 1, 1'b1, 0};
      vecs[4] = '{16'h9000, 16'h2000, 1'b1, 2, 1'b0, 1, 1'b1, 0};
      vecs[5] = '{16'h3abc, 16'h1234, 1'b1, 0, 1'b0, 1, 1'b1, 0};
      vecs[6] = '{16'h4fff, 16'hf000, 1'b0, 1, 1'b1, 4, 1'b0, 3};
      vecs[7] = '{16'h0123, 16'h0123, 1'b1, 0, 1'b0, 7, 1'b0, 6};
      vecs[8] = '{16'h5555, 16'h6000, 1'b1, 3, 1'b1, 1, 1'b1, 0};
      vecs[9] = '{16'h3000, 16'h5000, 1'b1, 1, 1'b0, 7, 1'b0, 6};

      for (int i = 0; i < 10; i++)
         run_txn(vecs[i].a, vecs[i].b, vecs[i].two, vecs[i].hold, vecs[i].junk,
                 vecs[i].lat, vecs[i].err, vecs[i].low);

      // Randomized fetches checked against the reference rules.
      for (int i = 0; i < 40; i++) begin
         ra   = {4'($urandom_range(0, 7)), 12'($urandom)};
         rb   = {4'($urandom_range(0, 7)), 12'($urandom)};
         rtwo = 1'($urandom);
         rerr = !unit_ok(ra) || (rtwo && !unit_ok(rb));
         rlat = rerr ? 1 : (rtwo ? 2 * READ_LAT + 3 : READ_LAT + 2);
         rlow = rerr ? 0 : (rtwo ? 2 * (READ_LAT + 1) : READ_LAT + 1);
         run_txn(ra, rb, rtwo, int'($urandom_range(0, 3)), 1'($urandom), rlat, rerr, rlow);
      end

      // Reset during RD_B with the counter at 1.
      @(negedge Clk);
      ReqValid  = 1'b1;
      ReqSrcA   = 16'h2010;
      ReqSrcB   = 16'h4008;
      ReqTwoOps = 1'b1;
      @(negedge Clk);
      ReqValid = 1'b0;
      repeat (READ_LAT + 2) @(negedge Clk);
      chk("midrd_in_rdb", address, 16'h4008);
      chk("midrd_strobe", nRead, 0);
      nReset = 1'b0;
      @(negedge Clk);
      chk("midrd_nread_released", nRead, 1);
      chk("midrd_opvalid", OpValid, 0);
      chk("midrd_operand_a", OperandA, 0);
      nReset = 1'b1;
      #1;
      chk("midrd_idle", ReqReady, 1);
      for (int i = 0; i < 10; i++) begin
         @(negedge Clk);
         chk("midrd_no_valid", OpValid, 0);
      end
      $display("txn reset-mid-read a=2010 b=4008 two=1");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule
